// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 codes, state encoding and request legality check for the load/store unit
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    // A request is rejected if its funct3 is undefined for its direction or its address
    // is not naturally aligned to the access size (funct3[1:0] encodes the size).
    function automatic logic lsu_bad_req(input logic       is_store,
                                         input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
        logic illegal;
        logic misaligned;
        if (is_store) begin
            illegal = (funct3 != F3_SB) && (funct3 != F3_SH) && (funct3 != F3_SW);
        end else begin
            illegal = (funct3 != F3_LB) && (funct3 != F3_LH) && (funct3 != F3_LW) &&
                      (funct3 != F3_LBU) && (funct3 != F3_LHU);
        end
        case (funct3[1:0])
            2'b01:   misaligned = addr_lo[0];
            2'b10:   misaligned = (addr_lo != 2'b00);
            default: misaligned = 1'b0;
        endcase
        return illegal || misaligned;
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// rtl/lsu_byte_lane.sv - little-endian lane extraction for loads and lane merge for stores
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    output logic [31:0] load_val,
    output logic [31:0] store_word
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Select the addressed lane of the word and sign/zero-extend it for loads.
    always_comb begin
        byte_v   = 8'h00;
        half_v   = addr_lo[1] ? word[31:16] : word[15:0];
        load_val = 32'h0;
        case (addr_lo)
            2'b00:   byte_v = word[7:0];
            2'b01:   byte_v = word[15:8];
            2'b10:   byte_v = word[23:16];
            default: byte_v = word[31:24];
        endcase
        case (funct3)
            F3_LB:   load_val = {{24{byte_v[7]}}, byte_v};
            F3_LH:   load_val = {{16{half_v[15]}}, half_v};
            F3_LW:   load_val = word;
            F3_LBU:  load_val = {24'h0, byte_v};
            F3_LHU:  load_val = {16'h0, half_v};
            default: load_val = 32'h0;
        endcase
    end

    // Overwrite only the addressed lane; the remaining lanes come from the read word.
    always_comb begin
        store_word = word;
        case (funct3)
            F3_SB: begin
                case (addr_lo)
                    2'b00:   store_word[7:0]   = wdata[7:0];
                    2'b01:   store_word[15:8]  = wdata[7:0];
                    2'b10:   store_word[23:16] = wdata[7:0];
                    default: store_word[31:24] = wdata[7:0];
                endcase
            end
            F3_SH: begin
                if (addr_lo[1]) store_word[31:16] = wdata[15:0];
                else            store_word[15:0]  = wdata[15:0];
            end
            F3_SW:   store_word = wdata;
            default: store_word = word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte/halfword/word load-store sequencer with read-modify-write for narrow stores
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        err,
    output logic        busy,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_out,
    input  logic [31:0] mem_data_in,
    output logic        mem_we
);

    localparam int unsigned      CNT_W     = 4;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYCLES - 1);

    lsu_state_t       state;
    lsu_state_t       next_state;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic [2:0]       funct3_q;
    logic             is_store_q;
    logic             err_q;
    logic [31:0]      rdata_q;
    logic [31:0]      mem_data_out_q;
    logic [CNT_W-1:0] wait_cnt;
    logic             req_bad;
    logic [31:0]      load_val;
    logic [31:0]      store_word;

    assign req_bad      = lsu_bad_req(is_store, funct3, addr[1:0]);
    assign mem_address  = {addr_q[31:2], 2'b00};
    assign mem_data_out = mem_data_out_q;
    assign rdata        = rdata_q;
    assign err          = err_q && (state == DONE);

    lsu_byte_lane u_lane (
        .word       (mem_data_in),
        .addr_lo    (addr_q[1:0]),
        .funct3     (funct3_q),
        .wdata      (wdata_q),
        .load_val   (load_val),
        .store_word (store_word)
    );

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= next_state;
    end

    // Next-state decode; done/busy/mem_we come from the state register alone.
    always_comb begin
        next_state = state;
        done       = 1'b0;
        mem_we     = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (start) begin
                    if (req_bad)                          next_state = DONE;
                    else if (is_store && funct3 == F3_SW) next_state = WR;
                    else                                  next_state = RD;
                end
            end
            RD: begin
                if (wait_cnt == '0) next_state = is_store_q ? WR : DONE;
            end
            WR: begin
                mem_we     = 1'b1;
                next_state = DONE;
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Request capture on acceptance, wait countdown, and read-word capture on the last RD edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_q         <= 32'h0;
            wdata_q        <= 32'h0;
            funct3_q       <= 3'b000;
            is_store_q     <= 1'b0;
            err_q          <= 1'b0;
            rdata_q        <= 32'h0;
            mem_data_out_q <= 32'h0;
            wait_cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        addr_q     <= addr;
                        wdata_q    <= wdata;
                        funct3_q   <= funct3;
                        is_store_q <= is_store;
                        err_q      <= req_bad;
                        rdata_q    <= 32'h0;
                        wait_cnt   <= WAIT_LAST;
                        if (!req_bad && is_store && funct3 == F3_SW) mem_data_out_q <= wdata;
                    end
                end
                RD: begin
                    if (wait_cnt == '0) begin
                        if (is_store_q) mem_data_out_q <= store_word;
                        else            rdata_q        <= load_val;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit against a byte-array memory model
module tb_load_store_unit;

    localparam int WAIT = 1;

    logic        clk      = 1'b0;
    logic        resetn   = 1'b0;
    logic        start    = 1'b0;
    logic        is_store = 1'b0;
    logic [2:0]  funct3   = 3'b000;
    logic [31:0] addr     = 32'h0;
    logic [31:0] wdata    = 32'h0;
    logic [31:0] rdata;
    logic        done;
    logic        err;
    logic        busy;
    logic [31:0] mem_address;
    logic [31:0] mem_data_out;
    logic [31:0] mem_data_in;
    logic        mem_we;

    logic [31:0] tb_mem [0:63];
    logic        pl_en   = 1'b0;
    logic [5:0]  pl_idx  = 6'd0;
    logic [31:0] pl_data = 32'h0;
    logic [7:0]  ref_mem [0:255];

    int n_checks = 0;
    int n_fail   = 0;

    int          obs_lat, obs_we;
    logic [31:0] obs_wdat, obs_rd;
    logic        obs_err, obs_to, obs_addr_ok, obs_busy_ok;
    int          exp_lat, exp_we;
    logic [31:0] exp_wdat, exp_rd;
    logic        exp_err;

    load_store_unit #(.WAIT_CYCLES(WAIT)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .start        (start),
        .is_store     (is_store),
        .funct3       (funct3),
        .addr         (addr),
        .wdata        (wdata),
        .rdata        (rdata),
        .done         (done),
        .err          (err),
        .busy         (busy),
        .mem_address  (mem_address),
        .mem_data_out (mem_data_out),
        .mem_data_in  (mem_data_in),
        .mem_we       (mem_we)
    );

    always #5 clk = ~clk;

    assign mem_data_in = tb_mem[mem_address[7:2]];

    always @(posedge clk) begin
        if (mem_we)     tb_mem[mem_address[7:2]] <= mem_data_out;
        else if (pl_en) tb_mem[pl_idx] <= pl_data;
    end

    function automatic logic [31:0] ref_word(input logic [7:0] a);
        int b;
        b = int'(a) & 252;
        return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
    endfunction

    task automatic mem_set(input logic [7:0] a, input logic [31:0] w);
        int b;
        b = int'(a) & 252;
        @(negedge clk);
        pl_en = 1'b1; pl_idx = a[7:2]; pl_data = w;
        @(negedge clk);
        pl_en = 1'b0;
        for (int i = 0; i < 4; i++) ref_mem[b+i] = w[8*i +: 8];
    endtask

    // Reference: memory as bytes, access size from funct3[1:0], extension by arithmetic.
    task automatic ref_op(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        int sz, base;
        logic legal;
        logic [31:0] v;
        sz    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        legal = st ? (f3 <= 3'd2) : !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        base  = int'(a[7:0]);
        exp_rd = 32'h0; exp_err = 1'b0; exp_we = 0; exp_wdat = 32'h0;
        if (!legal || (base % sz) != 0) begin
            exp_err = 1'b1;
            exp_lat = 1;
        end else if (!st) begin
            v = 32'h0;
            for (int i = 0; i < sz; i++) v = v | (32'(ref_mem[base+i]) << (8*i));
            if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~((32'd1 << (8*sz)) - 32'd1);
            exp_rd  = v;
            exp_lat = WAIT + 1;
        end else begin
            for (int i = 0; i < sz; i++) ref_mem[base+i] = wd[8*i +: 8];
            exp_we   = 1;
            exp_wdat = ref_word(a[7:0]);
            exp_lat  = (sz == 4) ? 2 : WAIT + 2;
        end
    endtask

    // Issue one request and record what the DUT does until done (bounded).
    task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        start = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
        obs_lat = 0; obs_we = 0; obs_wdat = 32'h0; obs_rd = 32'h0; obs_err = 1'b0;
        obs_to = 1'b1; obs_addr_ok = 1'b1; obs_busy_ok = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (mem_address !== {a[31:2], 2'b00}) obs_addr_ok = 1'b0;
            if (busy !== 1'b1) obs_busy_ok = 1'b0;
            if (mem_we === 1'b1) begin obs_we++; obs_wdat = mem_data_out; end
            if (done === 1'b1) begin
                obs_lat = c; obs_rd = rdata; obs_err = err; obs_to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_checks++; if ({done, err, busy, mem_we} !== 4'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b expected 0000", {done, err, busy, mem_we}); end
        n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
        n_checks++; if (mem_address !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", mem_address); end
        n_checks++; if (mem_data_out !== 32'h0) begin n_fail++; $display("FAIL reset_wdout: got %h expected 0", mem_data_out); end
        for (int i = 0; i < 64; i++) mem_set(8'(i*4), $urandom);
        mem_set(8'h40, 32'h8899AABB);
        @(negedge clk);
        resetn = 1'b1; start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h40;
        @(negedge clk);
        start = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL first_accept: busy got %b expected 1", busy); end
        repeat (WAIT) @(negedge clk);
        n_checks++; if (done !== 1'b1 || rdata !== 32'h8899AABB) begin n_fail++; $display("FAIL first_load: done %b rdata %h expected 1 8899aabb", done, rdata); end
    endtask

    task automatic test_directed;
        mem_set(8'h40, 32'h8899AABB);
        mem_set(8'h10, 32'h11223344);
        ref_op(1'b0, 3'b010, 32'h40, 32'h0); run_op(1'b0, 3'b010, 32'h40, 32'h0);
        n_checks++; if (obs_lat != 2 || obs_rd !== 32'h8899AABB || obs_err !== 1'b0 || obs_we != 0) begin n_fail++; $display("FAIL lw: lat %0d rd %h err %b we %0d expected 2 8899aabb 0 0", obs_lat, obs_rd, obs_err, obs_we); end
        ref_op(1'b0, 3'b000, 32'h43, 32'h0); run_op(1'b0, 3'b000, 32'h43, 32'h0);
        n_checks++; if (obs_rd !== 32'hFFFFFF88) begin n_fail++; $display("FAIL lb: got %h expected ffffff88", obs_rd); end
        ref_op(1'b0, 3'b100, 32'h43, 32'h0); run_op(1'b0, 3'b100, 32'h43, 32'h0);
        n_checks++; if (obs_rd !== 32'h00000088) begin n_fail++; $display("FAIL lbu: got %h expected 00000088", obs_rd); end
        ref_op(1'b0, 3'b001, 32'h42, 32'h0); run_op(1'b0, 3'b001, 32'h42, 32'h0);
        n_checks++; if (obs_rd !== 32'hFFFF8899) begin n_fail++; $display("FAIL lh: got %h expected ffff8899", obs_rd); end
        ref_op(1'b1, 3'b000, 32'h11, 32'hA5); run_op(1'b1, 3'b000, 32'h11, 32'hA5);
        n_checks++; if (obs_we != 1 || obs_wdat !== 32'h1122A544 || obs_lat != 3 || obs_rd !== 32'h0) begin n_fail++; $display("FAIL sb: we %0d data %h lat %0d rd %h expected 1 1122a544 3 0", obs_we, obs_wdat, obs_lat, obs_rd); end
        n_checks++; if (tb_mem[4] !== 32'h1122A544) begin n_fail++; $display("FAIL sb_mem: got %h expected 1122a544", tb_mem[4]); end
        ref_op(1'b0, 3'b010, 32'h42, 32'h0); run_op(1'b0, 3'b010, 32'h42, 32'h0);
        n_checks++; if (obs_lat != 1 || obs_err !== 1'b1 || obs_we != 0 || obs_rd !== 32'h0) begin n_fail++; $display("FAIL lw_misaligned: lat %0d err %b we %0d rd %h expected 1 1 0 0", obs_lat, obs_err, obs_we, obs_rd); end
        ref_op(1'b1, 3'b001, 32'h13, 32'hFFFF); run_op(1'b1, 3'b001, 32'h13, 32'hFFFF);
        n_checks++; if (obs_lat != 1 || obs_err !== 1'b1 || obs_we != 0) begin n_fail++; $display("FAIL sh_misaligned: lat %0d err %b we %0d expected 1 1 0", obs_lat, obs_err, obs_we); end
        n_checks++; if (tb_mem[4] !== 32'h1122A544 || tb_mem[16] !== 32'h8899AABB) begin n_fail++; $display("FAIL misaligned_mem: got %h %h expected 1122a544 8899aabb", tb_mem[4], tb_mem[16]); end
    endtask

    task automatic test_random;
        logic st;
        logic [2:0] f3;
        logic [31:0] a, wd;
        for (int k = 0; k < 80; k++) begin
            st = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) f3 = st ? 3'($urandom_range(0, 2)) : ((k % 5 == 3) ? 3'b100 : (k % 5 == 4) ? 3'b101 : 3'(k % 3));
            a = $urandom;
            if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
            wd = $urandom;
            ref_op(st, f3, a, wd);
            run_op(st, f3, a, wd);
            n_checks++; if (obs_to !== 1'b0 || obs_lat != exp_lat) begin n_fail++; $display("FAIL rnd_lat[%0d]: got %0d expected %0d", k, obs_lat, exp_lat); end
            n_checks++; if (obs_err !== exp_err) begin n_fail++; $display("FAIL rnd_err[%0d]: got %b expected %b", k, obs_err, exp_err); end
            n_checks++; if (obs_rd !== exp_rd) begin n_fail++; $display("FAIL rnd_rdata[%0d]: got %h expected %h", k, obs_rd, exp_rd); end
            n_checks++; if (obs_we != exp_we) begin n_fail++; $display("FAIL rnd_we_count[%0d]: got %0d expected %0d", k, obs_we, exp_we); end
            n_checks++; if (obs_wdat !== exp_wdat) begin n_fail++; $display("FAIL rnd_wdata[%0d]: got %h expected %h", k, obs_wdat, exp_wdat); end
            n_checks++; if (obs_addr_ok !== 1'b1 || obs_busy_ok !== 1'b1) begin n_fail++; $display("FAIL rnd_addr_busy[%0d]: got %b%b expected 11", k, obs_addr_ok, obs_busy_ok); end
            n_checks++; if (tb_mem[a[7:2]] !== ref_word(a[7:0])) begin n_fail++; $display("FAIL rnd_mem[%0d]: got %h expected %h", k, tb_mem[a[7:2]], ref_word(a[7:0])); end
        end
    endtask

    task automatic test_reset_mid_op;
        logic [31:0] w0;
        int bad;
        w0 = $urandom;
        mem_set(8'h20, w0);
        @(negedge clk);
        start = 1'b1; is_store = 1'b1; funct3 = 3'b001; addr = 32'h22; wdata = $urandom;
        @(negedge clk);
        start = 1'b0;
        #2 resetn = 1'b0;
        #1;
        n_checks++; if ({done, err, busy, mem_we} !== 4'b0) begin n_fail++; $display("FAIL abort_rd_ctrl: got %b expected 0000", {done, err, busy, mem_we}); end
        n_checks++; if (rdata !== 32'h0 || mem_address !== 32'h0 || mem_data_out !== 32'h0) begin n_fail++; $display("FAIL abort_rd_data: got %h %h %h expected 0 0 0", rdata, mem_address, mem_data_out); end
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (done !== 1'b0 || mem_we !== 1'b0 || busy !== 1'b0) bad++;
        end
        resetn = 1'b1;
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL abort_rd_quiet: got %0d active cycles expected 0", bad); end
        n_checks++; if (tb_mem[8] !== w0) begin n_fail++; $display("FAIL abort_rd_mem: got %h expected %h", tb_mem[8], w0); end
        @(negedge clk);
        start = 1'b1; is_store = 1'b1; funct3 = 3'b000; addr = 32'h21; wdata = $urandom;
        @(negedge clk);
        start = 1'b0;
        repeat (WAIT) @(negedge clk);
        n_checks++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL abort_wr_pre: mem_we got %b expected 1", mem_we); end
        #2 resetn = 1'b0;
        #1;
        n_checks++; if (mem_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL abort_wr_ctrl: got %b%b%b expected 000", mem_we, busy, done); end
        @(negedge clk);
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_wr_done: got %b expected 0", done); end
        @(negedge clk);
        resetn = 1'b1;
        n_checks++; if (tb_mem[8] !== w0) begin n_fail++; $display("FAIL abort_wr_mem: got %h expected %h", tb_mem[8], w0); end
        ref_op(1'b0, 3'b010, 32'h20, 32'h0);
        run_op(1'b0, 3'b010, 32'h20, 32'h0);
        n_checks++; if (obs_rd !== w0 || obs_lat != WAIT + 1 || obs_err !== 1'b0) begin n_fail++; $display("FAIL after_reset_lw: rd %h lat %0d err %b expected %h %0d 0", obs_rd, obs_lat, obs_err, w0, WAIT + 1); end
    endtask

    task automatic test_back_to_back;
        logic st;
        logic [31:0] a, wd;
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            st = 1'(k % 2);
            a  = $urandom & 32'hFFFF_FFFC;
            wd = $urandom;
            start = 1'b1; is_store = st; funct3 = 3'b010; addr = a; wdata = wd;
            n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL b2b_idle[%0d]: busy %b done %b expected 0 0", k, busy, done); end
            ref_op(st, 3'b010, a, wd);
            for (int c = 1; c <= exp_lat; c++) begin
                @(negedge clk);
                addr = $urandom; wdata = $urandom; is_store = 1'($urandom_range(0, 1)); funct3 = 3'($urandom_range(0, 7));
                n_checks++; if (busy !== 1'b1 || done !== (c == exp_lat)) begin n_fail++; $display("FAIL b2b_state[%0d.%0d]: busy %b done %b expected 1 %b", k, c, busy, done, (c == exp_lat)); end
                n_checks++; if (mem_we !== (st && c == 1)) begin n_fail++; $display("FAIL b2b_we[%0d.%0d]: got %b expected %b", k, c, mem_we, (st && c == 1)); end
                n_checks++; if (mem_address !== a) begin n_fail++; $display("FAIL b2b_addr[%0d.%0d]: got %h expected %h", k, c, mem_address, a); end
                if (st && c == 1) begin
                    n_checks++; if (mem_data_out !== wd) begin n_fail++; $display("FAIL b2b_wdata[%0d]: got %h expected %h", k, mem_data_out, wd); end
                end
                if (c == exp_lat) begin
                    n_checks++; if (rdata !== exp_rd) begin n_fail++; $display("FAIL b2b_rdata[%0d]: got %h expected %h", k, rdata, exp_rd); end
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_reset_mid_op();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1: cycles the word address is held before read data is sampled (legal range 1..15).
REQ-002 SHALL have clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have resetn, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have start, input, 1: request pulse, sampled only in IDLE.
REQ-005 SHALL have is_store, input, 1: 1 = store, 0 = load.
REQ-006 SHALL have funct3, input, 3: access type. Loads: LB=000, LH=001, LW=010, LBU=100, LHU=101. Stores: SB=000, SH=001, SW=010.
REQ-007 SHALL have addr, input, 32: byte address.
REQ-008 SHALL have wdata, input, 32: store data, right-aligned.
REQ-009 SHALL have rdata, output, 32: extended load result, valid while done=1.
REQ-010 SHALL have done, output, 1: one-cycle completion pulse.
REQ-011 SHALL have err, output, 1: misaligned or illegal request, valid with done.
REQ-012 SHALL have busy, output, 1: high whenever state is not IDLE.
REQ-013 SHALL have mem_address, output, 32: word-aligned address to memory.
REQ-014 SHALL have mem_data_out, output, 32: write word to memory data input.
REQ-015 SHALL have mem_data_in, input, 32: memory read word, combinational from mem_address.
REQ-016 SHALL have mem_we, output, 1: memory write enable.

Function
REQ-017 SHALL implement states IDLE, RD, WR and DONE.
REQ-018 In IDLE with start=1, the unit SHALL latch addr, funct3, is_store and wdata; start in any other state SHALL be ignored.
REQ-019 mem_address SHALL be {addr_q[31:2],2'b00} and stay stable from the first cycle after acceptance until leaving DONE.
REQ-020 Misalignment SHALL be detected on acceptance:
- halfword with addr[0]=1;
- word with addr[1:0]!=0;
- undefined funct3 (load 011/110/111; store 011..111).
These SHALL go IDLE->DONE with err=1, rdata=0 and no mem_we.
REQ-021 A load SHALL go IDLE -> RD for WAIT_CYCLES cycles (tracked by a counter) -> DONE. The read word SHALL be captured at the last RD edge.
REQ-022 Load latency: done SHALL be high in cycle WAIT_CYCLES+1 after the start cycle.
REQ-023 Load extraction SHALL be little-endian, byte lane addr[1:0], halfword lane addr[1]. LB/LH SHALL sign-extend; LBU/LHU SHALL zero-extend.
REQ-024 SW SHALL go IDLE -> WR -> DONE, with mem_we=1 for exactly the single WR cycle and mem_data_out=wdata.
REQ-025 SB/SH SHALL go IDLE -> RD (WAIT_CYCLES) -> WR -> DONE as read-modify-write. Only the addressed byte/halfword lane of the captured word SHALL be replaced with wdata[7:0]/wdata[15:0]; the other lanes SHALL be preserved.
REQ-026 mem_we SHALL be decoded from the state register only; it SHALL be 0 in IDLE, RD and DONE.
REQ-027 mem_data_out SHALL hold the merged word register and keep it until the next store.
REQ-028 done SHALL be high for exactly one cycle (DONE), after which the state SHALL return to IDLE. A new start is accepted no earlier than the cycle after DONE.
REQ-029 For stores, rdata SHALL be 0 when done is high.

Reset
REQ-030 While resetn=0 the unit SHALL immediately (asynchronously) force: state=IDLE, done=0, err=0, busy=0, mem_we=0, rdata=0, mem_address=0, mem_data_out=0, wait counter=0.
REQ-031 Reset asserted mid-operation (including during WR) SHALL abort without a further write and without a done pulse.
REQ-032 The first start SHALL be accepted on the first rising edge with resetn=1.

Structure
REQ-033 A shared package lsu_pkg SHALL hold the funct3 load/store constants and the state enumeration.
REQ-034 The combinational lane logic SHALL live in sub-module lsu_byte_lane:
- inputs: word, addr[1:0], funct3, wdata;
- outputs: extended load value, merged store word.
REQ-035 The FSM, wait counter and registers SHALL stay in load_store_unit; there SHALL be no other sub-modules.

Verification
REQ-036 LW: memory word at 0x40 = 0x8899AABB, WAIT_CYCLES=1, start load LW addr=0x40 -> done in cycle 2, rdata=0x8899AABB, err=0, mem_we never 1.
REQ-037 LB/LBU: same word, addr=0x43 -> LB rdata=0xFFFFFF88, LBU rdata=0x00000088. LH addr=0x42 -> rdata=0xFFFF8899.
REQ-038 SB: word 0x11223344 at 0x10, SB addr=0x11 wdata=0xA5 -> single mem_we pulse with mem_data_out=0x1122A544, done in cycle 3.
REQ-039 Misaligned: LW addr=0x42 and SH addr=0x13 -> done in cycle 1, err=1, no mem_we, memory unchanged.
REQ-040 Reset mid-SH: assert resetn=0 during RD -> all outputs 0 immediately, no mem_we, no done. After release, an LW completes normally.
REQ-041 Back-to-back: start held high continuously -> requests accepted only in IDLE, one done per accepted request, busy high from the cycle after acceptance through DONE.
